// File: rtl/piece_pkg.sv
// Shared defaults, FSM state type and counter limit for the piece queue.
package piece_pkg;

    localparam int unsigned PIECE_W_DEF = 2;
    localparam int unsigned DEPTH_DEF   = 4;

    localparam logic [7:0] DEALT_MAX = 8'd255;

    typedef enum logic {
        FILL = 1'b0,
        FULL = 1'b1
    } state_t;

endpackage

// File: rtl/piece_fifo.sv
// Circular storage for upcoming pieces: head/next read ports, occupancy count, sync clear.
module piece_fifo
    import piece_pkg::*;
#(
    parameter int unsigned DEPTH   = DEPTH_DEF,
    parameter int unsigned PIECE_W = PIECE_W_DEF
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic                      i_clear,
    input  logic                      i_push,
    input  logic                      i_pop,
    input  logic [PIECE_W-1:0]        i_wdata,
    output logic [PIECE_W-1:0]        o_head,
    output logic [PIECE_W-1:0]        o_next,
    output logic [$clog2(DEPTH):0]    o_count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [PIECE_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]      r_wr_ptr;
    logic [AW-1:0]      r_rd_ptr;
    logic [CW-1:0]      r_count;
    logic [AW-1:0]      w_rd_nxt;

    // Pointers are exactly AW bits wide, so the natural overflow wraps modulo DEPTH.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (i_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            if (i_push && !i_pop) begin
                r_count <= r_count + CW'(1);
            end else if (i_pop && !i_push) begin
                r_count <= r_count - CW'(1);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_push && !i_clear) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    assign w_rd_nxt = r_rd_ptr + AW'(1);
    assign o_head   = r_mem[r_rd_ptr];
    assign o_next   = r_mem[w_rd_nxt];
    assign o_count  = r_count;

endmodule

// File: rtl/piece_queue.sv
// Upcoming-piece queue: FILL/FULL FSM, dealt counter and optional anti-repeat filter.
// Define PIECE_QUEUE_NO_REPEAT_EN to bump a value that would repeat the last push.
module piece_queue
    import piece_pkg::*;
#(
    parameter int unsigned DEPTH   = DEPTH_DEF,
    parameter int unsigned PIECE_W = PIECE_W_DEF
) (
    input  logic                   clka,
    input  logic                   restart_n,
    input  logic [PIECE_W-1:0]     random,
    input  logic                   flush,
    input  logic                   pop,
    output logic                   piece_valid,
    output logic [PIECE_W-1:0]     piece_out,
    output logic [PIECE_W-1:0]     preview,
    output logic [$clog2(DEPTH):0] count,
    output logic [7:0]             dealt_cnt
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;

    state_t             r_state;
    logic [7:0]         r_dealt;
    logic [CW-1:0]      w_count;
    logic [PIECE_W-1:0] w_head;
    logic [PIECE_W-1:0] w_next;
    logic [PIECE_W-1:0] w_push_data;
    logic               w_valid;
    logic               w_push;
    logic               w_pop_acc;

    assign w_valid   = (w_count != '0);
    assign w_push    = (r_state == FILL) && !flush;
    assign w_pop_acc = pop && w_valid && !flush;

`ifdef PIECE_QUEUE_NO_REPEAT_EN
    logic [PIECE_W-1:0] r_last;
    logic               r_last_vld;

    always_ff @(posedge clka or negedge restart_n) begin
        if (!restart_n) begin
            r_last     <= '0;
            r_last_vld <= 1'b0;
        end else if (flush) begin
            r_last_vld <= 1'b0;
        end else if (w_push) begin
            r_last     <= w_push_data;
            r_last_vld <= 1'b1;
        end
    end

    assign w_push_data = (r_last_vld && (random == r_last)) ? random + PIECE_W'(1) : random;
`else
    assign w_push_data = random;
`endif

    // FULL is entered only when a push lands on the last free slot without a matching pop.
    always_ff @(posedge clka or negedge restart_n) begin
        if (!restart_n) begin
            r_state <= FILL;
            r_dealt <= '0;
        end else begin
            if (w_pop_acc && (r_dealt != DEALT_MAX)) begin
                r_dealt <= r_dealt + 8'd1;
            end
            if (flush) begin
                r_state <= FILL;
            end else begin
                case (r_state)
                    FILL: begin
                        if (w_push && !w_pop_acc && (w_count == CW'(DEPTH - 1))) begin
                            r_state <= FULL;
                        end
                    end
                    FULL: begin
                        if (w_pop_acc) begin
                            r_state <= FILL;
                        end
                    end
                    default: r_state <= FILL;
                endcase
            end
        end
    end

    piece_fifo #(
        .DEPTH   (DEPTH),
        .PIECE_W (PIECE_W)
    ) u_fifo (
        .i_clk   (clka),
        .i_rst_n (restart_n),
        .i_clear (flush),
        .i_push  (w_push),
        .i_pop   (w_pop_acc),
        .i_wdata (w_push_data),
        .o_head  (w_head),
        .o_next  (w_next),
        .o_count (w_count)
    );

    // Storage is not reset, so reads are masked by occupancy to hide stale slots.
    assign piece_valid = w_valid;
    assign piece_out   = w_valid ? w_head : '0;
    assign preview     = (w_count >= CW'(2)) ? w_next : '0;
    assign count       = w_count;
    assign dealt_cnt   = r_dealt;

endmodule

// File: tb/tb_piece_queue.sv
// Randomized and directed bench for piece_queue against a queue-based reference model.
`timescale 1ns/1ps
module tb_piece_queue;

    localparam int DEP = 4;
    localparam int PW  = 2;

    logic          clka      = 1'b0;
    logic          restart_n = 1'b0;
    logic          flush     = 1'b0;
    logic          pop       = 1'b0;
    logic [PW-1:0] random    = '0;
    logic          piece_valid;
    logic [PW-1:0] piece_out;
    logic [PW-1:0] preview;
    logic [2:0]    count;
    logic [7:0]    dealt_cnt;

    int n_err = 0;
    int n_chk = 0;
    int m_q[$];
    int m_dealt = 0;
`ifdef PIECE_QUEUE_NO_REPEAT_EN
    int m_last     = 0;
    bit m_last_vld = 1'b0;
`endif

    piece_queue #(
        .DEPTH   (DEP),
        .PIECE_W (PW)
    ) u_dut (
        .clka        (clka),
        .restart_n   (restart_n),
        .random      (random),
        .flush       (flush),
        .pop         (pop),
        .piece_valid (piece_valid),
        .piece_out   (piece_out),
        .preview     (preview),
        .count       (count),
        .dealt_cnt   (dealt_cnt)
    );

    always #5 clka = ~clka;

    function automatic int e_out();
        return (m_q.size() > 0) ? m_q[0] : 0;
    endfunction

    function automatic int e_prev();
        return (m_q.size() > 1) ? m_q[1] : 0;
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_dealt = 0;
`ifdef PIECE_QUEUE_NO_REPEAT_EN
        m_last     = 0;
        m_last_vld = 1'b0;
`endif
    endtask

    // One clock edge of the queue rules: pop the front, then push unless the queue was full.
    task automatic model_edge(input logic f, input logic p, input int r);
        int v;
        bit was_full;
        bit take;
        if (f) begin
            m_q.delete();
`ifdef PIECE_QUEUE_NO_REPEAT_EN
            m_last_vld = 1'b0;
`endif
            return;
        end
        was_full = (m_q.size() == DEP);
        take     = p && (m_q.size() > 0);
        if (take) begin
            void'(m_q.pop_front());
            if (m_dealt < 255) m_dealt++;
        end
        if (!was_full) begin
            v = r;
`ifdef PIECE_QUEUE_NO_REPEAT_EN
            if (m_last_vld && (r == m_last)) v = (r + 1) % (1 << PW);
            m_last     = v;
            m_last_vld = 1'b1;
`endif
            m_q.push_back(v);
        end
    endtask

    task automatic drive(input logic f, input logic p, input int r);
        flush  = f;
        pop    = p;
        random = PW'(r);
        @(posedge clka);
        model_edge(f, p, r);
        #1;
    endtask

    task automatic apply_reset(input int r);
        flush     = 1'b0;
        pop       = 1'b0;
        random    = PW'(r);
        restart_n = 1'b0;
        repeat (2) @(posedge clka);
        #3;
        model_reset();
        restart_n = 1'b1;
    endtask

    task automatic test_reset();
        #12;
        n_chk++;
        if (piece_valid !== 1'b0) begin
            n_err++; $display("FAIL reset_valid got=%b want=0", piece_valid);
        end
        n_chk++;
        if (piece_out !== '0) begin
            n_err++; $display("FAIL reset_out got=%0d want=0", piece_out);
        end
        n_chk++;
        if (preview !== '0) begin
            n_err++; $display("FAIL reset_preview got=%0d want=0", preview);
        end
        n_chk++;
        if (count !== 3'd0) begin
            n_err++; $display("FAIL reset_count got=%0d want=0", count);
        end
        n_chk++;
        if (dealt_cnt !== 8'd0) begin
            n_err++; $display("FAIL reset_dealt got=%0d want=0", dealt_cnt);
        end
    endtask

    task automatic test_fill();
        apply_reset(2);
        #1;
        n_chk++;
        if (piece_valid !== 1'b0) begin
            n_err++; $display("FAIL fill_valid_pre got=%b want=0", piece_valid);
        end
        for (int i = 1; i <= DEP; i++) begin
            drive(1'b0, 1'b0, 2);
            n_chk++;
            if (count !== 3'(i)) begin
                n_err++; $display("FAIL fill_count[%0d] got=%0d want=%0d", i, count, i);
            end
            n_chk++;
            if ((piece_valid !== 1'b1) || (piece_out !== 2'd2)) begin
                n_err++;
                $display("FAIL fill_head[%0d] got=%b/%0d want=1/2", i, piece_valid, piece_out);
            end
        end
        drive(1'b0, 1'b0, 2);
        n_chk++;
        if (count !== 3'd4) begin
            n_err++; $display("FAIL fill_full_hold got=%0d want=4", count);
        end
    endtask

    task automatic test_order();
        apply_reset(0);
        for (int i = 0; i < 4; i++) drive(1'b0, 1'b0, i);
        for (int i = 0; i < 4; i++) begin
            n_chk++;
            if (piece_out !== 2'(i)) begin
                n_err++; $display("FAIL order_head[%0d] got=%0d want=%0d", i, piece_out, i);
            end
            drive(1'b0, 1'b1, 3);
        end
        n_chk++;
        if (dealt_cnt !== 8'd4) begin
            n_err++; $display("FAIL order_dealt got=%0d want=4", dealt_cnt);
        end
    endtask

    task automatic test_full_pop();
        int snap[$];
        for (int i = 0; i < 8 && m_q.size() < DEP; i++) drive(1'b0, 1'b0, $urandom_range(0, 3));
        n_chk++;
        if (count !== 3'd4) begin
            n_err++; $display("FAIL fullpop_start got=%0d want=4", count);
        end
        snap = m_q;
        drive(1'b0, 1'b1, $urandom_range(0, 3));
        n_chk++;
        if (count !== 3'd3) begin
            n_err++; $display("FAIL fullpop_dip got=%0d want=3", count);
        end
        drive(1'b0, 1'b0, $urandom_range(0, 3));
        n_chk++;
        if (count !== 3'd4) begin
            n_err++; $display("FAIL fullpop_refill got=%0d want=4", count);
        end
        n_chk++;
        if (preview !== 2'(snap[2])) begin
            n_err++; $display("FAIL fullpop_preview got=%0d want=%0d", preview, snap[2]);
        end
        for (int i = 1; i < DEP; i++) begin
            n_chk++;
            if (piece_out !== 2'(snap[i])) begin
                n_err++; $display("FAIL fullpop_head[%0d] got=%0d want=%0d", i, piece_out, snap[i]);
            end
            drive(1'b0, 1'b1, $urandom_range(0, 3));
        end
    endtask

    task automatic test_flush();
        int saved;
        int r;
        for (int i = 0; i < 8 && m_q.size() < DEP; i++) drive(1'b0, 1'b0, $urandom_range(0, 3));
        saved = m_dealt;
        drive(1'b1, 1'b1, $urandom_range(0, 3));
        n_chk++;
        if ((count !== 3'd0) || (piece_valid !== 1'b0)) begin
            n_err++; $display("FAIL flush_clear got=%0d/%b want=0/0", count, piece_valid);
        end
        n_chk++;
        if (dealt_cnt !== 8'(saved)) begin
            n_err++; $display("FAIL flush_dealt got=%0d want=%0d", dealt_cnt, saved);
        end
        r = $urandom_range(0, 3);
        drive(1'b0, 1'b0, r);
        n_chk++;
        if ((count !== 3'd1) || (piece_out !== 2'(r))) begin
            n_err++; $display("FAIL flush_refill got=%0d/%0d want=1/%0d", count, piece_out, r);
        end
    endtask

    task automatic test_anti_repeat();
        int exp_seq[4];
`ifdef PIECE_QUEUE_NO_REPEAT_EN
        exp_seq = '{1, 2, 1, 2};
`else
        exp_seq = '{1, 1, 1, 1};
`endif
        drive(1'b1, 1'b0, 0);
        for (int i = 0; i < 4; i++) drive(1'b0, 1'b0, 1);
        for (int i = 0; i < 4; i++) begin
            n_chk++;
            if (piece_out !== 2'(exp_seq[i])) begin
                n_err++; $display("FAIL repeat_head[%0d] got=%0d want=%0d", i, piece_out, exp_seq[i]);
            end
            drive(1'b0, 1'b1, 1);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 200; i++) begin
            drive(($urandom_range(0, 15) == 0), $urandom_range(0, 1) == 1, $urandom_range(0, 3));
            n_chk++;
            if ((count !== 3'(m_q.size())) || (piece_valid !== (m_q.size() > 0))) begin
                n_err++; $display("FAIL rand_count[%0d] got=%0d want=%0d", i, count, m_q.size());
            end
            n_chk++;
            if ((piece_out !== 2'(e_out())) || (preview !== 2'(e_prev()))) begin
                n_err++;
                $display("FAIL rand_data[%0d] got=%0d/%0d want=%0d/%0d",
                         i, piece_out, preview, e_out(), e_prev());
            end
            n_chk++;
            if (dealt_cnt !== 8'(m_dealt)) begin
                n_err++; $display("FAIL rand_dealt[%0d] got=%0d want=%0d", i, dealt_cnt, m_dealt);
            end
        end
    endtask

    task automatic test_saturation();
        repeat (300) drive(1'b0, 1'b1, $urandom_range(0, 3));
        n_chk++;
        if (dealt_cnt !== 8'd255) begin
            n_err++; $display("FAIL sat_dealt got=%0d want=255", dealt_cnt);
        end
        n_chk++;
        if ((count !== 3'(m_q.size())) || (piece_out !== 2'(e_out()))) begin
            n_err++; $display("FAIL sat_queue got=%0d/%0d want=%0d/%0d",
                              count, piece_out, m_q.size(), e_out());
        end
        drive(1'b1, 1'b0, 0);
        drive(1'b0, 1'b0, 1);
        drive(1'b0, 1'b0, 2);
        #2;
        restart_n = 1'b0;
        #1;
        model_reset();
        n_chk++;
        if ((piece_valid !== 1'b0) || (count !== 3'd0)) begin
            n_err++; $display("FAIL midrst_count got=%b/%0d want=0/0", piece_valid, count);
        end
        n_chk++;
        if ((piece_out !== '0) || (preview !== '0)) begin
            n_err++; $display("FAIL midrst_data got=%0d/%0d want=0/0", piece_out, preview);
        end
        n_chk++;
        if (dealt_cnt !== 8'd0) begin
            n_err++; $display("FAIL midrst_dealt got=%0d want=0", dealt_cnt);
        end
        apply_reset(3);
        drive(1'b0, 1'b0, 3);
        n_chk++;
        if ((count !== 3'd1) || (piece_out !== 2'd3)) begin
            n_err++; $display("FAIL postrst_push got=%0d/%0d want=1/3", count, piece_out);
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_order();
        test_full_pop();
        test_flush();
        test_anti_repeat();
        test_random();
        test_saturation();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/piece_queue.md
PIECE_QUEUE -- requirements
Module: piece_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning the number of queued upcoming pieces (power of two, 2..16).
REQ-002 SHALL have parameter PIECE_W, default 2, meaning the width of the piece code and of the random input.
REQ-003 SHALL have port clka  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port restart_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port random  input  PIECE_W  free-running value from the random generator, sampled every cycle.
REQ-006 SHALL have port flush  input  1  synchronous queue clear, used on game restart.
REQ-007 SHALL have port pop  input  1  game logic consumes the head piece.
REQ-008 SHALL have port piece_valid  output  1  the head piece is valid (count > 0).
REQ-009 SHALL have port piece_out  output  PIECE_W  head piece, registered storage, combinational read of head slot.
REQ-010 SHALL have port preview  output  PIECE_W  the entry behind the head; 0 when count < 2.
REQ-011 SHALL have port count  output  $clog2(DEPTH)+1  current occupancy.
REQ-012 SHALL have port dealt_cnt  output  8  total pieces popped, saturating.

Function
REQ-013 SHALL implement FSM states FILL (count < DEPTH) and FULL (count == DEPTH); no other states.
REQ-014 SHALL push the sampled random value, or its remapped value per REQ-027, on every cycle in FILL.
REQ-015 SHALL make a pushed value visible as piece_out one cycle after the push edge.
REQ-016 SHALL remove the head on a cycle where pop && piece_valid; pop while empty is ignored without error.
REQ-017 SHALL, on simultaneous push and pop in FILL, keep count unchanged and keep order FIFO.
REQ-018 SHALL not push in FULL; a pop in FULL transitions to FILL and the push resumes next cycle.
REQ-019 SHALL wrap read and write pointers modulo DEPTH.
REQ-020 SHALL give flush priority over push and pop: count, pointers and the last-pushed valid flag cleared, state FILL, no push that cycle, dealt_cnt unchanged.
REQ-021 SHALL increment dealt_cnt on each accepted pop, holding at 255.

Reset
REQ-022 SHALL, on restart_n low, asynchronously clear count, pointers, dealt_cnt and the last-pushed valid flag, and enter FILL.
REQ-023 SHALL drive piece_valid=0, piece_out=0, preview=0, count=0 and dealt_cnt=0 during reset.
REQ-024 SHALL push on the first rising clka edge after restart_n deasserts.
REQ-025 SHALL return to the reset state when reset is asserted mid-operation, with no residual queue contents visible.

Configuration
REQ-026 SHALL compile the anti-repeat filter only when macro PIECE_QUEUE_NO_REPEAT_EN is defined.
REQ-027 SHALL, with PIECE_QUEUE_NO_REPEAT_EN defined, push (random+1) mod 2^PIECE_W when random equals the last pushed value and the last-pushed valid flag is set.
REQ-028 SHALL, without PIECE_QUEUE_NO_REPEAT_EN, push random unmodified and omit the last-pushed register.

Structure
REQ-029 SHALL place PIECE_W and DEPTH defaults, the FSM state typedef (FILL, FULL) and the dealt_cnt saturation constant 255 in shared package piece_pkg.
REQ-030 SHALL place storage and pointers in one sub-module, piece_fifo, and keep the FSM, filter and counter in piece_queue.

Verification
REQ-031 SHALL test reset-release fill: random held at 2 -> count 1,2,3,4 on successive edges, then FULL; piece_valid rises one cycle after release.
REQ-032 SHALL test order: random 0,1,2,3 over 4 cycles, then pop each cycle -> piece_out 0,1,2,3; dealt_cnt=4.
REQ-033 SHALL test full pop: in FULL, pop 1 cycle -> count 3 for one cycle, then 4 again; no value lost.
REQ-034 SHALL test flush priority: flush and pop asserted together with count=4 -> count 0, dealt_cnt unchanged, piece_valid 0, refill next cycle.
REQ-035 SHALL test anti-repeat: with macro defined, random held at 1 -> queue 1,2,1,2; without the macro -> queue 1,1,1,1.
REQ-036 SHALL test saturation and mid-run reset: 300 pops -> dealt_cnt=255; restart_n low mid-fill -> all outputs 0 immediately.
